mux_writeback_reg: RTL
======================

# mux_writeback_reg

Parametrised, registered write-back selector for the processor datapath. Picks one of N source buses (HI/LO, ALU, RS, memory, input, immediate, PC, …) by a select code. Captures the result, destination address and write-enable in a stall/flush-aware pipeline register that feeds the register file. Adds illegal-select detection, optional $zero write suppression and a saturating committed-write counter.

## Interface
- W, 32, data width of each source and of the output
- N, 7, number of source buses; legal select codes 0..N-1; N ≤ 2^SELW
- SELW, 3, select code width
- ADDRW, 5, register-address width
- CNTW, 16, width of the committed-write counter
- ZERO_GUARD, 1, when 1 a write to address 0 is suppressed

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- dadoRegControl  in  SELW  source select
- fontes  in  N*W  packed sources; source k at bits [k*W +: W]
- regDestino  in  ADDRW  destination register address
- escreveReg  in  1  write request for this instruction
- validoEntrada  in  1  inputs carry a valid instruction
- parada  in  1  stall: hold the output register
- descarta  in  1  flush: kill the output register
- limpaErro  in  1  synchronous clear of erroSelecao
- DadosRegistro  out  W  registered selected data
- regDestinoOut  out  ADDRW  registered destination address
- escreveRegOut  out  1  registered register-file write-enable
- validoSaida  out  1  output register holds a valid instruction
- erroSelecao  out  1  sticky: an illegal select was captured
- contEscritas  out  CNTW  saturating count of committed writes

## Operation
- Combinational select: sel_data = source[dadoRegControl] when dadoRegControl < N, else 0.
- Register update, evaluated on each rising clock edge in priority order:
  - descarta=1: validoSaida←0 and escreveRegOut←0. DadosRegistro and regDestinoOut hold. Flush beats stall.
  - parada=1: all output registers hold. Counter and error hold.
  - otherwise (capture): validoSaida←validoEntrada, DadosRegistro←sel_data, regDestinoOut←regDestino.
- escreveRegOut on capture is escreveReg & validoEntrada & legal & ~(ZERO_GUARD & regDestino==0). Here legal means dadoRegControl < N.
- Illegal select on a capture with validoEntrada=1:
  - data captured as 0;
  - escreveRegOut←0;
  - validoSaida←1;
  - erroSelecao←1.
- An illegal select with validoEntrada=0 is ignored and does not set the error.
- erroSelecao is sticky. It clears only on reset, or when limpaErro=1 and no new error is being set in the same cycle. Set wins over clear.
- contEscritas increments by 1 on every capture where the new escreveRegOut is 1. It saturates at 2^CNTW-1 and does not wrap. Flush and stall cycles never count.

## Timing
- Reset (asynchronous, immediate) forces every output to 0: DadosRegistro, regDestinoOut, escreveRegOut, validoSaida, erroSelecao and contEscritas.
- Latency is 1 cycle from inputs to outputs. Throughput is 1 instruction per cycle when parada=0.
- Outputs are purely registered; there is no combinational path from input to output.
- Stall may last any number of cycles; the outputs stay bit-identical throughout.
- Flush and stall in the same cycle: the flush takes effect.
- Reset asserted mid-stall or mid-flush clears immediately. After reset deasserts, the first edge with parada=0 captures normally.

## Test plan
- Reset then sweep: for each code 0..6 present fontes[k]=32'h1000_0000+k, regDestino=5'd8, escreveReg=1, validoEntrada=1. Next cycle: DadosRegistro=32'h1000_000k, escreveRegOut=1, contEscritas increments by 1 per cycle up to 7.
- Illegal select: code 3'b111 with validoEntrada=1. Next cycle: DadosRegistro=0, escreveRegOut=0, validoSaida=1, erroSelecao=1. The error persists after legal traffic resumes, clears after limpaErro=1 for one cycle, and is reasserted if limpaErro and a new illegal code arrive together.
- Stall/flush: capture ALU value 32'hDEAD_BEEF, then parada=1 for 3 cycles. The outputs hold and the counter is unchanged. Then descarta=1 together with parada=1: validoSaida=0, escreveRegOut=0, DadosRegistro still 32'hDEAD_BEEF.
- Zero guard: regDestino=0, escreveReg=1, legal select. Result: escreveRegOut=0 and the counter does not increment. With ZERO_GUARD=0 the same stimulus gives escreveRegOut=1.
- Saturation: instance with CNTW=3 and 10 consecutive committed writes. contEscritas stops at 7 and stays there.
- Asynchronous reset: assert reset between clock edges with validoSaida=1. All outputs are 0 before the next rising edge.

Source files
------------

// File: rtl/mux_writeback_reg.sv
// mux_writeback_reg
// Write-back source selector followed by a stall/flush-aware pipeline register
// that feeds the register file. It also flags illegal select codes (sticky),
// can suppress writes to register 0, and counts committed writes with saturation.
module mux_writeback_reg #(
   parameter int W          = 32,
   parameter int N          = 7,
   parameter int SELW       = 3,
   parameter int ADDRW      = 5,
   parameter int CNTW       = 16,
   parameter int ZERO_GUARD = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [SELW-1:0]  dadoRegControl,
   input  logic [N*W-1:0]   fontes,
   input  logic [ADDRW-1:0] regDestino,
   input  logic             escreveReg,
   input  logic             validoEntrada,
   input  logic             parada,
   input  logic             descarta,
   input  logic             limpaErro,
   output logic [W-1:0]     DadosRegistro,
   output logic [ADDRW-1:0] regDestinoOut,
   output logic             escreveRegOut,
   output logic             validoSaida,
   output logic             erroSelecao,
   output logic [CNTW-1:0]  contEscritas
);

   // ------------------------------------------------------------------
   // Source unpacking and one-hot decode of the select code.
   // A code with no matching source leaves every hit bit low, which
   // gives both the zero data and the "illegal" indication for free.
   // ------------------------------------------------------------------
   logic [W-1:0] src [N];
   logic [N-1:0] hit;

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_src
         assign src[gi] = fontes[gi*W +: W];
         assign hit[gi] = (dadoRegControl == SELW'(gi));
      end
   endgenerate

   logic         legal;
   logic [W-1:0] sel_data;

   assign legal = |hit;

   // AND-OR mux over the decoded sources; no match yields zero
   always_comb begin
      sel_data = '0;
      for (int k = 0; k < N; k++) begin
         if (hit[k]) begin
            sel_data = sel_data | src[k];
         end
      end
   end

   // ------------------------------------------------------------------
   // Register control
   // ------------------------------------------------------------------
   logic capture;
   logic dest_is_zero;
   logic zero_block;
   logic we_capture;
   logic err_set;
   logic err_clr;

   // Flush has priority over stall; capture only when neither is active.
   assign capture      = ~descarta & ~parada;
   assign dest_is_zero = (regDestino == '0);
   assign zero_block   = (ZERO_GUARD != 0) && dest_is_zero;
   assign we_capture   = escreveReg & validoEntrada & legal & ~zero_block;
   // Only a real instruction with a bad code raises the error.
   assign err_set      = capture & validoEntrada & ~legal;
   // A pure stall freezes the error flag together with everything else.
   assign err_clr      = limpaErro & ~(parada & ~descarta);

   logic [W-1:0]     data_q,  data_d;
   logic [ADDRW-1:0] dest_q,  dest_d;
   logic             we_q,    we_d;
   logic             valid_q, valid_d;
   logic             err_q,   err_d;
   logic [CNTW-1:0]  cnt_q,   cnt_d;

   logic cnt_full;
   assign cnt_full = (cnt_q == {CNTW{1'b1}});

   // Next-state for the pipeline register, error flag and write counter
   always_comb begin
      data_d  = data_q;
      dest_d  = dest_q;
      we_d    = we_q;
      valid_d = valid_q;
      err_d   = err_q;
      cnt_d   = cnt_q;

      if (descarta) begin
         // Kill the instruction but keep data/address for debug visibility.
         valid_d = 1'b0;
         we_d    = 1'b0;
      end else if (!parada) begin
         valid_d = validoEntrada;
         data_d  = sel_data;
         dest_d  = regDestino;
         we_d    = we_capture;
         if (we_capture && !cnt_full) begin
            cnt_d = cnt_q + 1'b1;
         end
      end

      // Setting the error wins over clearing it in the same cycle.
      if (err_set) begin
         err_d = 1'b1;
      end else if (err_clr) begin
         err_d = 1'b0;
      end
   end

   // State registers with asynchronous clear of every output
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         data_q  <= '0;
         dest_q  <= '0;
         we_q    <= 1'b0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         data_q  <= data_d;
         dest_q  <= dest_d;
         we_q    <= we_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign DadosRegistro = data_q;
   assign regDestinoOut = dest_q;
   assign escreveRegOut = we_q;
   assign validoSaida   = valid_q;
   assign erroSelecao   = err_q;
   assign contEscritas  = cnt_q;

endmodule
